// File: rtl/pu_riscv_verilog_pkg.sv
// Shared PU-RISCV definitions used by the branch predictor: counter encodings,
// predictor FSM states and the saturating counter update.
package pu_riscv_verilog_pkg;

  localparam logic [1:0] BP_SNT        = 2'b00;
  localparam logic [1:0] BP_WNT        = 2'b01;
  localparam logic [1:0] BP_WT         = 2'b10;
  localparam logic [1:0] BP_ST         = 2'b11;
  localparam logic [1:0] BP_INIT_VALUE = BP_WNT;

  typedef enum logic {
    BP_INIT,
    BP_RUN
  } bp_state_t;

  // The old counter travels with the update, so the new value needs no table read.
  function automatic logic [1:0] bp_cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == BP_ST)  ? BP_ST  : cnt + 2'd1;
    else       return (cnt == BP_SNT) ? BP_SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/pu_riscv_bp_if.sv
// Lookup (IF side) and update (branch unit side) signals of the branch predictor.
interface pu_riscv_bp_if #(
  parameter int XLEN           = 64,
  parameter int BP_GLOBAL_BITS = 2
) ();

  logic                      is_stall;
  logic [XLEN-1:0]           if_parcel_pc;
  logic [1:0]                bp_bp_predict;
  logic                      bp_ready;
  logic [XLEN-1:0]           ex_pc;
  logic [1:0]                bu_bp_predict;
  logic                      bu_bp_btaken;
  logic                      bu_bp_update;
  logic [BP_GLOBAL_BITS-1:0] bu_bp_history;

  modport master (
    output is_stall, if_parcel_pc, ex_pc, bu_bp_predict, bu_bp_btaken,
           bu_bp_update, bu_bp_history,
    input  bp_bp_predict, bp_ready
  );

  modport slave (
    input  is_stall, if_parcel_pc, ex_pc, bu_bp_predict, bu_bp_btaken,
           bu_bp_update, bu_bp_history,
    output bp_bp_predict, bp_ready
  );

endinterface

// File: rtl/pu_riscv_bp_ram.sv
// 1R/1W synchronous-read counter table with write-first bypass on address match.
module pu_riscv_bp_ram #(
  parameter int ABITS = 12,
  parameter int DBITS = 2
) (
  input  logic             clk,
  input  logic [ABITS-1:0] raddr_i,
  input  logic             re_i,
  output logic [DBITS-1:0] rdata_o,
  input  logic [ABITS-1:0] waddr_i,
  input  logic             we_i,
  input  logic [DBITS-1:0] wdata_i
);

  logic [DBITS-1:0] mem_q [2**ABITS];
  logic [DBITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pu_riscv_bp.sv
// Global-history branch predictor: 2-bit counter table indexed by {history, PC},
// looked up by IF and trained by the branch unit; cleared to weak-not-taken after reset.
module pu_riscv_bp
  import pu_riscv_verilog_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int HAS_RVC        = 1,
  parameter int BP_GLOBAL_BITS = 2,
  parameter int BP_LOCAL_BITS  = 10
) (
  input logic            rstn,
  input logic            clk,
  pu_riscv_bp_if.slave   bp_if
);

  localparam int ALIGN = (HAS_RVC != 0) ? 1 : 2;
  localparam int IDX_W = BP_GLOBAL_BITS + BP_LOCAL_BITS;

  bp_state_t        state_q;
  logic [IDX_W-1:0] init_cnt_q;
  logic             ready_q;

  logic [IDX_W-1:0] rd_idx, wr_idx, ram_waddr;
  logic             ram_we, ram_re;
  logic [1:0]       ram_wdata, ram_rdata;
  logic             unused_pc;

  assign rd_idx = {bp_if.bu_bp_history, bp_if.if_parcel_pc[ALIGN+BP_LOCAL_BITS-1:ALIGN]};
  assign wr_idx = {bp_if.bu_bp_history, bp_if.ex_pc[ALIGN+BP_LOCAL_BITS-1:ALIGN]};
  assign unused_pc = ^{bp_if.if_parcel_pc, bp_if.ex_pc};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= BP_INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        BP_INIT: begin
          init_cnt_q <= init_cnt_q + IDX_W'(1);
          if (&init_cnt_q) begin
            state_q <= BP_RUN;
            ready_q <= 1'b1;
          end
        end
        BP_RUN:  ready_q <= 1'b1;
        default: state_q <= BP_INIT;
      endcase
    end
  end

  // During INIT the write port belongs to the clearing walk; branch-unit updates are dropped.
  always_comb begin
    ram_we    = bp_if.bu_bp_update;
    ram_waddr = wr_idx;
    ram_wdata = bp_cnt_next(bp_if.bu_bp_predict, bp_if.bu_bp_btaken);
    if (state_q == BP_INIT) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt_q;
      ram_wdata = BP_INIT_VALUE;
    end
  end

  // Reads keep running through INIT so the first RUN cycle already holds a valid lookup.
  assign ram_re = ~bp_if.is_stall | (state_q == BP_INIT);

  pu_riscv_bp_ram #(
    .ABITS (IDX_W),
    .DBITS (2)
  ) u_ram (
    .clk     (clk),
    .raddr_i (rd_idx),
    .re_i    (ram_re),
    .rdata_o (ram_rdata),
    .waddr_i (ram_waddr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata)
  );

  assign bp_if.bp_bp_predict = ready_q ? ram_rdata : BP_SNT;
  assign bp_if.bp_ready      = ready_q;

endmodule

// File: tb/tb_pu_riscv_bp.sv
// Self-checking bench for pu_riscv_bp: directed scenarios plus random traffic
// compared against an array-based model of the counter table.
module tb_pu_riscv_bp;

  localparam int unsigned ENTRIES = 4096;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  pu_riscv_bp_if #(.XLEN(64), .BP_GLOBAL_BITS(2)) bpi ();

  pu_riscv_bp #(
    .XLEN           (64),
    .HAS_RVC        (1),
    .BP_GLOBAL_BITS (2),
    .BP_LOCAL_BITS  (10)
  ) dut (
    .rstn  (rstn),
    .clk   (clk),
    .bp_if (bpi)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned model_mem [ENTRIES];
  int unsigned exp_pred;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input logic [63:0] pc, input int unsigned hist);
    return hist * 1024 + int'((pc >> 1) % 1024);
  endfunction

  function automatic int unsigned sat(input int unsigned c, input bit tk);
    if (tk) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  // One cycle: drive, advance the model, clock, then compare the registered lookup.
  task automatic step(input logic stall, input logic [63:0] pc, input logic [63:0] xpc,
                      input logic [1:0] pr, input logic tk, input logic up, input logic [1:0] h);
    bpi.is_stall      = stall;
    bpi.if_parcel_pc  = pc;
    bpi.ex_pc         = xpc;
    bpi.bu_bp_predict = pr;
    bpi.bu_bp_btaken  = tk;
    bpi.bu_bp_update  = up;
    bpi.bu_bp_history = h;
    if (up) model_mem[idx_of(xpc, h)] = sat(pr, tk);
    if (!stall) exp_pred = model_mem[idx_of(pc, h)];
    @(posedge clk);
    #1;
    chk("predict", bpi.bp_bp_predict, exp_pred);
    chk("ready", bpi.bp_ready, 1);
  endtask

  task automatic do_reset();
    bpi.is_stall      = 1'b0;
    bpi.if_parcel_pc  = 64'h8000_0000;
    bpi.bu_bp_history = 2'b00;
    bpi.bu_bp_update  = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_ready", bpi.bp_ready, 0);
    chk("rst_pred", bpi.bp_bp_predict, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Counts cycles with bp_ready low after reset release, with junk updates that must be ignored.
  task automatic run_init(output int unsigned n_notready, output int unsigned n_badpred);
    n_notready = 0;
    n_badpred  = 0;
    while (bpi.bp_ready !== 1'b1 && n_notready < 5000) begin
      if (bpi.bp_bp_predict !== 2'b00) n_badpred++;
      n_notready++;
      bpi.bu_bp_update  = 1'($urandom);
      bpi.ex_pc         = 64'h8000_0000 + 64'(2 * $urandom_range(0, 31));
      bpi.bu_bp_predict = 2'($urandom);
      bpi.bu_bp_btaken  = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bpi.bu_bp_update = 1'b0;
    for (int i = 0; i < ENTRIES; i++) model_mem[i] = 1;
    exp_pred = 1;
  endtask

  task automatic reset_and_init(input string tag);
    int unsigned nr, nb;
    run_init(nr, nb);
    chk({tag, "_init_len"}, nr, ENTRIES);
    chk({tag, "_init_pred"}, nb, 0);
    chk({tag, "_first_pred"}, bpi.bp_bp_predict, 1);
  endtask

  task automatic random_traffic(input int unsigned n);
    logic [63:0] pc, xpc;
    for (int i = 0; i < n; i++) begin
      pc  = {32'($urandom), 32'h8000_0000 + 32'(2 * $urandom_range(0, 31))};
      xpc = ($urandom_range(0, 3) == 0) ? pc
            : {32'($urandom), 32'h8000_0000 + 32'(2 * $urandom_range(0, 31))};
      step($urandom_range(0, 7) == 0, pc, xpc, 2'($urandom), 1'($urandom),
           1'($urandom), 2'($urandom));
    end
  endtask

  localparam logic [63:0] PC0 = 64'h8000_0000;
  localparam logic [63:0] PCT = 64'h8000_0010;
  localparam logic [63:0] PCN = 64'h8000_0020;
  localparam logic [63:0] PCQ = 64'h8000_0030;
  localparam logic [63:0] PCR = 64'h8000_0040;
  localparam logic [63:0] PCS = 64'h8000_0050;

  initial begin
    bpi.ex_pc         = '0;
    bpi.bu_bp_predict = '0;
    bpi.bu_bp_btaken  = 1'b0;
    do_reset();
    reset_and_init("por");

    // Taken training up to strong-taken and saturation
    step(0, PC0, PCT, 2'b01, 1, 1, 2'b00);
    step(0, PC0, PCT, 2'b10, 1, 1, 2'b00);
    step(0, PC0, PCT, 2'b11, 1, 1, 2'b00);
    step(0, PCT, PC0, 2'b00, 0, 0, 2'b00);
    chk("taken_to_st", bpi.bp_bp_predict, 3);
    step(0, PC0, PCT, 2'b11, 1, 1, 2'b00);
    step(0, PCT, PC0, 2'b00, 0, 0, 2'b00);
    chk("taken_sat_hi", bpi.bp_bp_predict, 3);

    // Not-taken saturation and decrement
    step(0, PC0, PCN, 2'b00, 0, 1, 2'b00);
    step(0, PCN, PC0, 2'b00, 0, 0, 2'b00);
    chk("nt_sat_lo", bpi.bp_bp_predict, 0);
    step(0, PC0, PCN, 2'b10, 0, 1, 2'b00);
    step(0, PCN, PC0, 2'b00, 0, 0, 2'b00);
    chk("nt_dec", bpi.bp_bp_predict, 1);

    // Same-cycle update and lookup at one index
    step(0, PCQ, PCQ, 2'b01, 1, 1, 2'b00);
    chk("fwd_write_first", bpi.bp_bp_predict, 2);

    // History separates entries of one PC
    step(0, PC0, PCR, 2'b01, 1, 1, 2'b01);
    step(0, PCR, PC0, 2'b00, 0, 0, 2'b10);
    chk("hist_other_untouched", bpi.bp_bp_predict, 1);
    step(0, PCR, PC0, 2'b00, 0, 0, 2'b01);
    chk("hist_trained", bpi.bp_bp_predict, 2);

    // Stall holds the output; updates still land
    step(0, PCQ, PC0, 2'b00, 0, 0, 2'b00);
    step(1, PCT, PCS, 2'b01, 1, 1, 2'b00);
    chk("stall_hold0", bpi.bp_bp_predict, 2);
    step(1, PCN, PC0, 2'b00, 0, 0, 2'b00);
    chk("stall_hold1", bpi.bp_bp_predict, 2);
    step(1, PC0, PC0, 2'b00, 0, 0, 2'b00);
    chk("stall_hold2", bpi.bp_bp_predict, 2);
    step(0, PCS, PC0, 2'b00, 0, 0, 2'b00);
    chk("stall_update_kept", bpi.bp_bp_predict, 2);

    random_traffic(2000);

    // Reset in RUN clears trained entries
    do_reset();
    reset_and_init("run_rst");
    step(0, PCT, PC0, 2'b00, 0, 0, 2'b00);
    chk("post_reset_entry", bpi.bp_bp_predict, 1);

    random_traffic(300);

    // Reset during INIT restarts the walk from index 0
    do_reset();
    repeat (100) @(posedge clk);
    #1;
    do_reset();
    reset_and_init("init_rst");

    random_traffic(1000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
